// File: rtl/rmt_alu_pkg.sv
// rmt_alu_pkg: opcodes, FSM state type and page-table entry layout shared by the stateful ALU.
package rmt_alu_pkg;

    localparam logic [7:0] OP_ADD     = 8'h01;
    localparam logic [7:0] OP_SUB     = 8'h02;
    localparam logic [7:0] OP_SET     = 8'h0E;
    localparam logic [7:0] OP_LOAD    = 8'h0B;
    localparam logic [7:0] OP_STORE   = 8'h08;
    localparam logic [7:0] OP_LOADD   = 8'h07;
    localparam logic [7:0] OP_RMW_ADD = 8'h20;
    localparam logic [7:0] OP_RMW_MAX = 8'h21;
    localparam logic [7:0] OP_RMW_MIN = 8'h22;

    typedef enum logic [1:0] {IDLE, RD, OUT} alu_state_t;

    typedef struct packed {
        logic [7:0] addr_len;
        logic [7:0] base_addr;
    } page_entry_t;

    // Ops that touch the state RAM and are therefore subject to the page bounds check.
    function automatic logic is_stateful(input logic [7:0] op);
        return op inside {OP_LOAD, OP_STORE, OP_LOADD, OP_RMW_ADD, OP_RMW_MAX, OP_RMW_MIN};
    endfunction

endpackage

// File: rtl/alu_state_ram.sv
// alu_state_ram: simple dual-port state RAM, DATA_WIDTH x RAM_DEPTH, 1-cycle registered read, read-first.
//  clk      in   clock
//  we_i     in   write enable
//  waddr_i  in   write address
//  wdata_i  in   write data
//  re_i     in   read enable; rdata_o holds its value when low
//  raddr_i  in   read address
//  rdata_o  out  read data, one cycle after re_i (old contents on a same-address write)
module alu_state_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int RAM_DEPTH  = 32,
    parameter int ADDR_W     = 5
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/alu_stateful_rmw.sv
// alu_stateful_rmw: stateful RMT action ALU with stateless ops and paged read-modify-write state RAM.
//  clk, rst_n                  clock, synchronous active-low reset
//  action_in / action_valid    action word (opcode in top byte) and valid; taken while ready_out
//  operand_1/2/3_in            operands; op2 low bits give the page offset of stateful ops
//  page_tbl_out(_valid)        {addr_len, base_addr} page entry of the tenant, sampled on accept
//  ready_out                   high in IDLE only
//  container_out(_valid)       result and valid, held until ready_in
//  ready_in                    downstream accept
//  overflow_out                pulses on the handshake of a bounds/page faulted stateful op
module alu_stateful_rmw
    import rmt_alu_pkg::*;
#(
    parameter int STAGE_ID   = 0,
    parameter int ACTION_LEN = 64,
    parameter int DATA_WIDTH = 32,
    parameter int RAM_DEPTH  = 32,
    parameter bit SATURATE   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ACTION_LEN-1:0] action_in,
    input  logic                  action_valid,
    input  logic [DATA_WIDTH-1:0] operand_1_in,
    input  logic [DATA_WIDTH-1:0] operand_2_in,
    input  logic [DATA_WIDTH-1:0] operand_3_in,
    output logic                  ready_out,
    input  logic [15:0]           page_tbl_out,
    input  logic                  page_tbl_out_valid,
    output logic [DATA_WIDTH-1:0] container_out,
    output logic                  container_out_valid,
    input  logic                  ready_in,
    output logic                  overflow_out
);

    localparam int ADDR_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    alu_state_t            state_q, state_d;
    logic [7:0]            op_q;
    logic [DATA_WIDTH-1:0] op1_q, op2_q, op3_q;
    logic [ADDR_W-1:0]     phys_q;
    logic                  fault_q;
    logic                  fwd_vld_q, fwd_hit_q;
    logic [ADDR_W-1:0]     fwd_addr_q;
    logic [DATA_WIDTH-1:0] fwd_data_q;

    page_entry_t           page;
    logic [ADDR_W-1:0]     off;
    logic [15:0]           phys_full;
    logic                  accept, handshake, we, wr_op;
    logic [DATA_WIDTH-1:0] rdata, mem_val, calc, result, wdata;
    logic [DATA_WIDTH:0]   sum_inc, sum_add;
    logic                  unused_ok;

    // Widened sums carry out in the top bit; saturate to all-ones or drop the carry.
    function automatic logic [DATA_WIDTH-1:0] clamp(input logic [DATA_WIDTH:0] s);
        return (SATURATE && s[DATA_WIDTH]) ? '1 : s[DATA_WIDTH-1:0];
    endfunction

    assign page      = page_entry_t'(page_tbl_out);
    assign off       = operand_2_in[ADDR_W-1:0];
    assign phys_full = (16'(page.base_addr) + 16'(off)) % 16'(RAM_DEPTH);
    assign accept    = state_q == IDLE && action_valid;
    assign handshake = state_q == OUT && ready_in;
    assign unused_ok = ^{action_in[ACTION_LEN-9:0], phys_full[15:ADDR_W]} ^ (STAGE_ID < 0);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (action_valid) state_d = RD;
            RD:      state_d = OUT;
            OUT:     if (ready_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_out           = state_q == IDLE;
        container_out_valid = state_q == OUT;
        overflow_out        = handshake && fault_q;
        container_out       = container_out_valid ? result : '0;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q    <= action_in[ACTION_LEN-1 -: 8];
            op1_q   <= operand_1_in;
            op2_q   <= operand_2_in;
            op3_q   <= operand_3_in;
            phys_q  <= phys_full[ADDR_W-1:0];
            fault_q <= is_stateful(action_in[ACTION_LEN-1 -: 8]) &&
                       ((16'(off) > 16'(page.addr_len)) || !page_tbl_out_valid);
        end
        if (state_q == RD) fwd_hit_q <= fwd_vld_q && fwd_addr_q == phys_q;
    end

    // Last committed write; substitutes for the RAM output when it targets the address being read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fwd_vld_q <= 1'b0;
        end else if (we) begin
            fwd_vld_q  <= 1'b1;
            fwd_addr_q <= phys_q;
            fwd_data_q <= wdata;
        end
    end

    assign mem_val = fwd_hit_q ? fwd_data_q : rdata;
    assign sum_inc = (DATA_WIDTH+1)'(mem_val) + (DATA_WIDTH+1)'(1);
    assign sum_add = (DATA_WIDTH+1)'(mem_val) + (DATA_WIDTH+1)'(op1_q);

    always_comb begin
        calc = op3_q;
        case (op_q)
            OP_ADD:     calc = op1_q + op2_q;
            OP_SUB:     calc = op1_q - op2_q;
            OP_SET:     calc = op2_q;
            OP_LOAD:    calc = mem_val;
            OP_STORE:   calc = op3_q;
            OP_LOADD:   calc = clamp(sum_inc);
            OP_RMW_ADD: calc = clamp(sum_add);
            OP_RMW_MAX: calc = (mem_val > op1_q) ? mem_val : op1_q;
            OP_RMW_MIN: calc = (mem_val < op1_q) ? mem_val : op1_q;
            default:    calc = op3_q;
        endcase
    end

    assign result = fault_q ? op3_q : calc;
    assign wr_op  = is_stateful(op_q) && op_q != OP_LOAD;
    assign wdata  = (op_q == OP_STORE) ? op1_q : calc;
    // Commit only on the result handshake; rst_n gating drops a write pending at reset.
    assign we     = handshake && rst_n && wr_op && !fault_q;

    alu_state_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .RAM_DEPTH (RAM_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_ram (
        .clk    (clk),
        .we_i   (we),
        .waddr_i(phys_q),
        .wdata_i(wdata),
        .re_i   (state_q == RD),
        .raddr_i(phys_q),
        .rdata_o(rdata)
    );

endmodule

// File: tb/tb_alu_stateful_rmw.sv
// tb_alu_stateful_rmw: saturating and wrapping ALU instances on shared stimulus, table vectors plus random ops vs a model.
module tb_alu_stateful_rmw;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] action_in;
    logic        action_valid;
    logic [31:0] operand_1_in, operand_2_in, operand_3_in;
    logic [15:0] page_tbl_out;
    logic        page_tbl_out_valid;
    logic        ready_in;
    logic        ready_s, ready_w, vld_s, vld_w, ovf_s, ovf_w;
    logic [31:0] cout_s, cout_w;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] o1, o2, o3;
        logic [7:0]  base, len;
        logic        pv;
        int          stall;
        logic [31:0] exp_s, exp_w;
        logic        exp_ovf;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] mdl [2][32];
    localparam longint TOP = 64'h1_0000_0000;

    always #5 clk = ~clk;

    alu_stateful_rmw #(.SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .action_in(action_in), .action_valid(action_valid),
        .operand_1_in(operand_1_in), .operand_2_in(operand_2_in), .operand_3_in(operand_3_in),
        .ready_out(ready_s), .page_tbl_out(page_tbl_out), .page_tbl_out_valid(page_tbl_out_valid),
        .container_out(cout_s), .container_out_valid(vld_s), .ready_in(ready_in), .overflow_out(ovf_s)
    );

    alu_stateful_rmw #(.SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .action_in(action_in), .action_valid(action_valid),
        .operand_1_in(operand_1_in), .operand_2_in(operand_2_in), .operand_3_in(operand_3_in),
        .ready_out(ready_w), .page_tbl_out(page_tbl_out), .page_tbl_out_valid(page_tbl_out_valid),
        .container_out(cout_w), .container_out_valid(vld_w), .ready_in(ready_in), .overflow_out(ovf_w)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [7:0] op, input logic [31:0] o1, o2, o3,
                                input logic [7:0] b, l, input logic pv, input int st,
                                input logic [31:0] es, ew, input logic eo);
        vec_t v;
        v.op = op; v.o1 = o1; v.o2 = o2; v.o3 = o3; v.base = b; v.len = l; v.pv = pv;
        v.stall = st; v.exp_s = es; v.exp_w = ew; v.exp_ovf = eo;
        tbl.push_back(v);
    endfunction

    function automatic longint cl(input longint x, input bit sat);
        return (x < TOP) ? x : (sat ? TOP - 1 : x - TOP);
    endfunction

    // Reference: plain integer arithmetic on a per-instance memory image; k=0 saturating, k=1 wrapping.
    function automatic void model(input int k, input vec_t v, output logic [31:0] res, output logic ovf);
        longint m, o1, o2, r, nw;
        int off, phys;
        bit st, wr, sat;
        sat  = (k == 0);
        off  = int'(v.o2 % 32);
        phys = (int'(v.base) + off) % 32;
        st   = v.op inside {8'h0B, 8'h08, 8'h07, 8'h20, 8'h21, 8'h22};
        m    = longint'(mdl[k][phys]);
        o1   = longint'(v.o1);
        o2   = longint'(v.o2);
        wr   = 1'b0;
        nw   = 0;
        case (v.op)
            8'h01: r = (o1 + o2) % TOP;
            8'h02: r = (o1 - o2 + TOP) % TOP;
            8'h0E: r = o2;
            8'h0B: r = m;
            8'h08: begin r = longint'(v.o3); wr = 1; nw = o1; end
            8'h07: begin r = cl(m + 1, sat); wr = 1; nw = r; end
            8'h20: begin r = cl(m + o1, sat); wr = 1; nw = r; end
            8'h21: begin r = (m > o1) ? m : o1; wr = 1; nw = r; end
            8'h22: begin r = (m < o1) ? m : o1; wr = 1; nw = r; end
            default: r = longint'(v.o3);
        endcase
        ovf = st && (off > int'(v.len) || !v.pv);
        if (ovf) res = v.o3;
        else begin
            res = 32'(r);
            if (wr) mdl[k][phys] = 32'(nw);
        end
    endfunction

    task automatic run_vec(input vec_t vi, input bit use_model, input string tag);
        vec_t        v;
        logic [31:0] r0, r1;
        logic        f0, f1;
        int          lat;
        v = vi;
        model(0, v, r0, f0);
        model(1, v, r1, f1);
        if (use_model) begin
            v.exp_s = r0; v.exp_w = r1; v.exp_ovf = f0;
        end
        chk({tag, " rdy_idle"}, {30'b0, ready_s, ready_w}, 32'd3);
        action_in          = {v.op, $urandom, 24'($urandom)};
        action_valid       = 1'b1;
        operand_1_in       = v.o1;
        operand_2_in       = v.o2;
        operand_3_in       = v.o3;
        page_tbl_out       = {v.len, v.base};
        page_tbl_out_valid = v.pv;
        ready_in           = (v.stall == 0);
        @(posedge clk); #1;
        action_valid       = 1'b0;
        operand_1_in       = $urandom;
        operand_2_in       = $urandom;
        operand_3_in       = $urandom;
        page_tbl_out       = 16'($urandom);
        page_tbl_out_valid = 1'($urandom);
        action_in          = ~action_in;
        chk({tag, " rdy_busy"}, {31'b0, ready_s | ready_w}, 32'd0);
        lat = 1;
        while (!vld_s && lat < 6) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, lat, 32'd2);
        if (!vld_s) begin
            ready_in = 1'b1;
            return;
        end
        for (int i = 0; i < v.stall; i++) begin
            chk({tag, " stall_rdy"}, {31'b0, ready_s | ready_w}, 32'd0);
            chk({tag, " stall_vld"}, {31'b0, vld_s & vld_w}, 32'd1);
            chk({tag, " stall_out_s"}, cout_s, v.exp_s);
            chk({tag, " stall_out_w"}, cout_w, v.exp_w);
            chk({tag, " stall_ovf"}, {31'b0, ovf_s | ovf_w}, 32'd0);
            @(posedge clk); #1;
        end
        ready_in = 1'b1;
        #1;
        chk({tag, " out_s"}, cout_s, v.exp_s);
        chk({tag, " out_w"}, cout_w, v.exp_w);
        chk({tag, " ovf_s"}, {31'b0, ovf_s}, {31'b0, v.exp_ovf});
        chk({tag, " ovf_w"}, {31'b0, ovf_w}, {31'b0, v.exp_ovf});
        @(posedge clk); #1;
        chk({tag, " vld_drop"}, {30'b0, vld_s, vld_w}, 32'd0);
        chk({tag, " ovf_drop"}, {30'b0, ovf_s, ovf_w}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        v;
        logic [7:0]  ops [10];
        logic [31:0] o1;
        ops = '{8'h01, 8'h02, 8'h0E, 8'h0B, 8'h08, 8'h07, 8'h20, 8'h21, 8'h22, 8'h00};

        rst_n = 1'b0; ready_in = 1'b1; action_valid = 1'b0; action_in = '0;
        operand_1_in = '0; operand_2_in = '0; operand_3_in = '0;
        page_tbl_out = '0; page_tbl_out_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset rdy", {30'b0, ready_s, ready_w}, 32'd3);
        chk("reset vld", {30'b0, vld_s, vld_w}, 32'd0);
        chk("reset out_s", cout_s, 32'd0);
        chk("reset out_w", cout_w, 32'd0);
        chk("reset ovf", {30'b0, ovf_s, ovf_w}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 32; i++) begin
            v.op = 8'h08; v.o1 = 32'h100 + i; v.o2 = i; v.o3 = $urandom; v.base = 0; v.len = 31;
            v.pv = 1; v.stall = 0;
            run_vec(v, 1'b1, $sformatf("init%0d", i));
        end

        //   op     o1            o2            o3          base   len  pv st  exp_s         exp_w         ovf
        add(8'h08, 32'hAB,       32'd2,        32'h55,     8'd4,  8'd7, 1, 0, 32'h55,       32'h55,       0);
        add(8'h0B, 32'h0,        32'd2,        32'h0,      8'd4,  8'd7, 1, 0, 32'hAB,       32'hAB,       0);
        add(8'h08, 32'h0,        32'd0,        32'h1,      8'd8,  8'd7, 1, 0, 32'h1,        32'h1,        0);
        add(8'h07, 32'h0,        32'd0,        32'h0,      8'd8,  8'd7, 1, 0, 32'h1,        32'h1,        0);
        add(8'h07, 32'h0,        32'd0,        32'h0,      8'd8,  8'd7, 1, 0, 32'h2,        32'h2,        0);
        add(8'h07, 32'h0,        32'd0,        32'h0,      8'd8,  8'd7, 1, 0, 32'h3,        32'h3,        0);
        add(8'h0B, 32'h0,        32'd0,        32'h0,      8'd8,  8'd7, 1, 0, 32'h3,        32'h3,        0);
        add(8'h08, 32'hDEAD,     32'd5,        32'h77,     8'd4,  8'd3, 1, 0, 32'h77,       32'h77,       1);
        add(8'h0B, 32'h0,        32'd5,        32'h0,      8'd4,  8'd7, 1, 0, 32'h109,      32'h109,      0);
        add(8'h0B, 32'h0,        32'd5,        32'h99,     8'd4,  8'd7, 0, 0, 32'h99,       32'h99,       1);
        add(8'h08, 32'h5,        32'd0,        32'h0,      8'd10, 8'd7, 1, 0, 32'h0,        32'h0,        0);
        add(8'h20, 32'h3,        32'd0,        32'h0,      8'd10, 8'd7, 1, 10, 32'h8,       32'h8,        0);
        add(8'h0B, 32'h0,        32'd0,        32'h0,      8'd10, 8'd7, 1, 0, 32'h8,        32'h8,        0);
        add(8'h21, 32'h14,       32'd0,        32'h0,      8'd10, 8'd7, 1, 0, 32'h14,       32'h14,       0);
        add(8'h22, 32'h1,        32'd0,        32'h0,      8'd10, 8'd7, 1, 2, 32'h1,        32'h1,        0);
        add(8'h0B, 32'h0,        32'd0,        32'h0,      8'd10, 8'd7, 1, 0, 32'h1,        32'h1,        0);
        add(8'h08, 32'hFFFFFFFE, 32'd0,        32'h2,      8'd12, 8'd7, 1, 0, 32'h2,        32'h2,        0);
        add(8'h20, 32'h5,        32'd0,        32'h0,      8'd12, 8'd7, 1, 3, 32'hFFFFFFFF, 32'h3,        0);
        add(8'h0B, 32'h0,        32'd0,        32'h0,      8'd12, 8'd7, 1, 0, 32'hFFFFFFFF, 32'h3,        0);
        add(8'h08, 32'hFFFFFFFF, 32'd0,        32'h4,      8'd13, 8'd7, 1, 0, 32'h4,        32'h4,        0);
        add(8'h07, 32'h0,        32'd0,        32'h0,      8'd13, 8'd7, 1, 0, 32'hFFFFFFFF, 32'h0,        0);
        add(8'h0B, 32'h0,        32'd0,        32'h0,      8'd13, 8'd7, 1, 0, 32'hFFFFFFFF, 32'h0,        0);
        add(8'h01, 32'h7,        32'h9,        32'h0,      8'd0,  8'd0, 1, 0, 32'h10,       32'h10,       0);
        add(8'h01, 32'hFFFFFFFF, 32'h2,        32'h0,      8'd0,  8'd0, 0, 0, 32'h1,        32'h1,        0);
        add(8'h02, 32'h3,        32'h5,        32'h0,      8'd0,  8'd0, 1, 1, 32'hFFFFFFFE, 32'hFFFFFFFE, 0);
        add(8'h0E, 32'h0,        32'h12345678, 32'h0,      8'd0,  8'd0, 1, 0, 32'h12345678, 32'h12345678, 0);
        add(8'h55, 32'h1,        32'h2,        32'hCAFE,   8'd0,  8'd0, 1, 0, 32'hCAFE,     32'hCAFE,     0);
        add(8'h08, 32'h33,       32'd3,        32'h5,      8'd0,  8'd3, 1, 0, 32'h5,        32'h5,        0);
        add(8'h0B, 32'h0,        32'd3,        32'h0,      8'd0,  8'd3, 1, 0, 32'h33,       32'h33,       0);
        add(8'h08, 32'h44,       32'd5,        32'h6,      8'd30, 8'd7, 1, 0, 32'h6,        32'h6,        0);
        add(8'h0B, 32'h0,        32'd3,        32'h0,      8'd0,  8'd31, 1, 0, 32'h44,      32'h44,       0);
        add(8'h0B, 32'h0,        32'd1,        32'h0,      8'd255, 8'd7, 1, 0, 32'h100,     32'h100,      0);

        foreach (tbl[i]) run_vec(tbl[i], 1'b0, $sformatf("row%0d", i));

        ready_in = 1'b0;
        action_in = {8'h08, 56'h0}; action_valid = 1'b1;
        operand_1_in = 32'hBEEF; operand_2_in = 32'd20; operand_3_in = 32'h1;
        page_tbl_out = {8'd31, 8'd0}; page_tbl_out_valid = 1'b1;
        @(posedge clk); #1;
        action_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mid pre_vld", {30'b0, vld_s, vld_w}, 32'd3);
        chk("rst_mid pre_out", cout_s, 32'h1);
        rst_n = 1'b0; ready_in = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid vld", {30'b0, vld_s, vld_w}, 32'd0);
        chk("rst_mid out", cout_s | cout_w, 32'd0);
        chk("rst_mid ovf", {30'b0, ovf_s, ovf_w}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid rdy", {30'b0, ready_s, ready_w}, 32'd3);
        v.op = 8'h0B; v.o1 = 0; v.o2 = 20; v.o3 = 0; v.base = 0; v.len = 31; v.pv = 1; v.stall = 0;
        v.exp_s = 32'h114; v.exp_w = 32'h114; v.exp_ovf = 0;
        run_vec(v, 1'b0, "rst_mid mem_kept");

        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 2))
                0:       o1 = $urandom;
                1:       o1 = 32'hFFFFFFFF - $urandom_range(0, 8);
                default: o1 = $urandom_range(0, 16);
            endcase
            v.op    = ops[$urandom_range(0, 9)];
            if (v.op == 8'h00) v.op = 8'($urandom);
            v.o1    = o1;
            v.o2    = $urandom;
            v.o3    = $urandom;
            v.base  = 8'($urandom);
            v.len   = 8'($urandom_range(0, 31));
            v.pv    = ($urandom_range(0, 7) != 0);
            v.stall = $urandom_range(0, 2);
            run_vec(v, 1'b1, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
